// File: rtl/apb_mem_slave_v2.sv
// rtl/apb_mem_slave_v2.sv - APB4 word memory slave with byte strobes, wait states, RO region
// Request is captured at the setup edge; completion flags come from state/counter only.
module apb_mem_slave_v2 #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_WORDS    = 0
) (
   input  logic                    PCLK,
   input  logic                    PPRESETn,
   input  logic                    PSEL_i,
   input  logic                    PENABLE_i,
   input  logic                    PWRITE_i,
   input  logic [ADDR_WIDTH-1:0]   PADDR_i,
   input  logic [DATA_WIDTH-1:0]   PWDATA_i,
   input  logic [DATA_WIDTH/8-1:0] PSTRB_i,
   output logic                    PREADY_o,
   output logic [DATA_WIDTH-1:0]   PRDATA_o,
   output logic                    PSLVERR_o
);
   localparam int NB  = DATA_WIDTH / 8;
   localparam int OFS = $clog2(NB);
   localparam int IW  = ADDR_WIDTH - OFS;
   localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [IW-1:0] DEPTH_L = IW'(MEM_DEPTH);
   localparam logic [3:0]    WAIT_L  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]         strb_q, strb_d;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

   logic ro_hit, err, done, latch;

   generate
      if (RO_WORDS > 0) begin : g_ro
         assign ro_hit = idx_q < IW'(RO_WORDS);
      end else begin : g_no_ro
         assign ro_hit = 1'b0;
      end
      if (OFS > 0) begin : g_ofs
         logic unused_ofs;
         assign unused_ofs = ^PADDR_i[OFS-1:0];
      end
   endgenerate

   assign err       = (idx_q >= DEPTH_L) || (wr_q && ro_hit);
   assign PREADY_o  = (state_q == ACCESS) && (cnt_q == WAIT_L);
   assign done      = PREADY_o && PSEL_i;
   assign PSLVERR_o = PREADY_o && err;
   assign PRDATA_o  = (PREADY_o && !wr_q && !err) ? mem_q[idx_q[MW-1:0]] : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      mem_d   = mem_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (PSEL_i && !PENABLE_i) begin
               state_d = SETUP;
               latch   = 1'b1;
            end
         end
         SETUP: begin
            if (!PSEL_i) begin
               state_d = IDLE;
            end else if (PENABLE_i) begin
               state_d = ACCESS;
               cnt_d   = '0;
            end else begin
               latch = 1'b1;
            end
         end
         ACCESS: begin
            if (done) begin
               if (wr_q && !err) begin
                  for (int b = 0; b < NB; b++) begin
                     if (strb_q[b]) mem_d[idx_q[MW-1:0]][b*8 +: 8] = wdata_q[b*8 +: 8];
                  end
               end
               // A fresh setup phase on the completing edge is taken as back-to-back.
               if (!PENABLE_i) begin
                  state_d = SETUP;
                  latch   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (!PSEL_i || !PENABLE_i) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (latch) begin
         idx_d   = PADDR_i[ADDR_WIDTH-1:OFS];
         wr_d    = PWRITE_i;
         wdata_d = PWDATA_i;
         strb_d  = PSTRB_i;
      end
   end

   always_ff @(posedge PCLK or negedge PPRESETn) begin
      if (!PPRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// tb/tb_apb_mem_slave_v2.sv - directed bench: zero-wait default slave and 3-wait RO slave
module tb_apb_mem_slave_v2;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready0, pslverr0, pready1, pslverr1;
   logic [31:0] prdata0, prdata1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   apb_mem_slave_v2 u_dut0 (
      .PCLK(clk), .PPRESETn(resetn), .PSEL_i(psel0), .PENABLE_i(penable),
      .PWRITE_i(pwrite), .PADDR_i(paddr), .PWDATA_i(pwdata), .PSTRB_i(pstrb),
      .PREADY_o(pready0), .PRDATA_o(prdata0), .PSLVERR_o(pslverr0)
   );

   apb_mem_slave_v2 #(.MEM_DEPTH(16), .WAIT_CYCLES(3), .RO_WORDS(4)) u_dut1 (
      .PCLK(clk), .PPRESETn(resetn), .PSEL_i(psel1), .PENABLE_i(penable),
      .PWRITE_i(pwrite), .PADDR_i(paddr), .PWDATA_i(pwdata), .PSTRB_i(pstrb),
      .PREADY_o(pready1), .PRDATA_o(prdata1), .PSLVERR_o(pslverr1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Setup phase, then access phase with the bus address/data scrambled to prove latching.
   task automatic start(input int which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      @(posedge clk); #1;
      psel0 = (which == 0); psel1 = (which == 1); penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1; paddr = ~addr; pwdata = ~data; pstrb = ~strb;
   endtask

   task automatic release_bus();
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
   endtask

   task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rd, output logic er, output int n);
      logic fin = 1'b0;
      start(which, wr, addr, data, strb);
      n = 0; rd = '0; er = 1'b0;
      while (!fin && n < 40) begin
         @(negedge clk);
         n++;
         if ((which == 0) ? pready0 : pready1) begin
            fin = 1'b1;
            rd  = (which == 0) ? prdata0 : prdata1;
            er  = (which == 0) ? pslverr0 : pslverr1;
         end
      end
      if (!fin) check("pready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      release_bus();
   endtask

   logic [31:0] rd;
   logic        er;
   int          n;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pready", {31'd0, pready0}, 32'd0);
      check("rst_prdata", prdata0, 32'd0);
      check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, n);
      check("w0_wr_err", {31'd0, er}, 32'd0);
      check("w0_wr_lat", n, 32'd2);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
      check("w0_rd_lat", n, 32'd2);
      check("w0_rd_data", rd, 32'hDEADBEEF);
      check("w0_rd_err", {31'd0, er}, 32'd0);

      xfer(0, 1'b1, 32'h8, 32'h11223344, 4'hF, rd, er, n);
      xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, er, n);
      xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, n);
      check("strb_data", rd, 32'h11BB33DD);

      xfer(0, 1'b0, 32'h100, 32'h0, 4'hF, rd, er, n);
      check("oor_rd_err", {31'd0, er}, 32'd1);
      check("oor_rd_data", rd, 32'd0);
      xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, n);
      check("oor_wr_err", {31'd0, er}, 32'd1);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, n);
      check("oor_alias0", rd, 32'd0);
      xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, n);
      check("byte_off_rd", rd, 32'hDEADBEEF);

      xfer(0, 1'b1, 32'h10, 32'h0, 4'h0, rd, er, n);
      check("strb0_err", {31'd0, er}, 32'd0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
      check("strb0_keep", rd, 32'hDEADBEEF);

      xfer(1, 1'b1, 32'h4, 32'h5, 4'hF, rd, er, n);
      check("ro_wr_err", {31'd0, er}, 32'd1);
      check("w3_lat", n, 32'd5);
      xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, n);
      check("ro_rd_data", rd, 32'd0);
      check("ro_rd_err", {31'd0, er}, 32'd0);
      xfer(1, 1'b1, 32'h10, 32'h12345678, 4'hF, rd, er, n);
      check("rw_wr_err", {31'd0, er}, 32'd0);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
      check("raw_data", rd, 32'h12345678);
      check("raw_lat", n, 32'd5);

      start(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      @(posedge clk); #1;
      @(posedge clk); #1;
      release_bus();
      @(negedge clk);
      check("drop_pready", {31'd0, pready1}, 32'd0);
      check("drop_pslverr", {31'd0, pslverr1}, 32'd0);
      @(negedge clk);
      check("drop_idle_rdy", {31'd0, pready1}, 32'd0);
      xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, n);
      check("drop_nowrite", rd, 32'd0);
      check("drop_next_lat", n, 32'd5);

      start(1, 1'b0, 32'h10, 32'h0, 4'h0);
      repeat (5) @(negedge clk);
      check("rst_mid_rdy_pre", {31'd0, pready1}, 32'd1);
      check("rst_mid_data_pre", prdata1, 32'h12345678);
      resetn = 1'b0;
      #1;
      check("rst_mid_rdy", {31'd0, pready1}, 32'd0);
      check("rst_mid_data", prdata1, 32'd0);
      @(posedge clk); #1;
      release_bus();
      resetn = 1'b1;
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
      check("rst_mem_clear", rd, 32'd0);
      check("rst_next_lat", n, 32'd5);
      xfer(1, 1'b1, 32'h18, 32'h0000BEEF, 4'h3, rd, er, n);
      xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, rd, er, n);
      check("rst_next_data", rd, 32'h0000BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
